// File: rtl/lap_stopwatch.sv
// lap_stopwatch: MM:SS BCD stopwatch with lap-hold display, up/down counting,
// preset load and four 7-segment digit decoders.
//
// Ports
//   clock       rising-edge system clock
//   reset       asynchronous active-low reset
//   start_stop  level input; each rising edge toggles run/stop
//   clear       synchronous clear of count, prescaler, run, hold and done
//   lap         level input; rising edge toggles display hold while running,
//               forces hold off while stopped
//   down        count direction, 0 = up, 1 = down
//   load        synchronous preset strobe, accepted only while stopped
//   load_val    BCD preset {m1,m0,s1,s0}; out-of-range digits saturate
//   bcd         live count {m1,m0,s1,s0}
//   seg0..seg3  decoded display digits s0, s1, m0, m1, bit order {g,f,e,d,c,b,a}
//   running     high while counting
//   done        one-cycle pulse on up-mode wrap, latched flag at down-mode end
//   tick        one-cycle pulse per elapsed second while running
module lap_stopwatch #(
  parameter int unsigned TICK_DIV       = 50000000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        lap,
  input  logic        down,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] bcd,
  output logic [6:0]  seg0,
  output logic [6:0]  seg1,
  output logic [6:0]  seg2,
  output logic [6:0]  seg3,
  output logic        running,
  output logic        done,
  output logic        tick
);

  localparam logic [25:0] TICK_LAST = 26'(TICK_DIV - 1);

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } run_state_e;

  run_state_e  state_q, state_d;
  logic [25:0] presc_q, presc_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] disp_q, disp_d;
  logic        hold_q, hold_d;
  logic        done_lat_q, done_lat_d;
  logic        done_pls_q, done_pls_d;
  logic        start_q, lap_q;

  logic        is_run;
  logic        start_edge, lap_edge;
  logic [15:0] cnt_up, cnt_dn;
  logic        wrap_up;

  function automatic logic [3:0] sat(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

  function automatic logic [6:0] seg_dec(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'b1000000;
      4'd1:    p = 7'b1111001;
      4'd2:    p = 7'b0100100;
      4'd3:    p = 7'b0110000;
      4'd4:    p = 7'b0011001;
      4'd5:    p = 7'b0010010;
      4'd6:    p = 7'b0000010;
      4'd7:    p = 7'b1111000;
      4'd8:    p = 7'b0000000;
      4'd9:    p = 7'b0010000;
      default: p = 7'b1111111;
    endcase
    return SEG_ACTIVE_LOW ? p : ~p;
  endfunction

  assign is_run     = (state_q == ST_RUN);
  assign start_edge = start_stop & ~start_q;
  assign lap_edge   = lap & ~lap_q;

  // BCD increment with full ripple carry; digits are always in range because
  // loads saturate, so equality against the limit is sufficient.
  always_comb begin
    cnt_up  = cnt_q;
    wrap_up = 1'b0;
    if (cnt_q[3:0] != 4'd9) begin
      cnt_up[3:0] = cnt_q[3:0] + 4'd1;
    end else begin
      cnt_up[3:0] = '0;
      if (cnt_q[7:4] != 4'd5) begin
        cnt_up[7:4] = cnt_q[7:4] + 4'd1;
      end else begin
        cnt_up[7:4] = '0;
        if (cnt_q[11:8] != 4'd9) begin
          cnt_up[11:8] = cnt_q[11:8] + 4'd1;
        end else begin
          cnt_up[11:8] = '0;
          if (cnt_q[15:12] != 4'd5) begin
            cnt_up[15:12] = cnt_q[15:12] + 4'd1;
          end else begin
            cnt_up[15:12] = '0;
            wrap_up       = 1'b1;
          end
        end
      end
    end
  end

  // BCD decrement with full ripple borrow; the 00:00 / 00:01 cases are
  // handled as the terminal condition before this result is used.
  always_comb begin
    cnt_dn = cnt_q;
    if (cnt_q[3:0] != 4'd0) begin
      cnt_dn[3:0] = cnt_q[3:0] - 4'd1;
    end else begin
      cnt_dn[3:0] = 4'd9;
      if (cnt_q[7:4] != 4'd0) begin
        cnt_dn[7:4] = cnt_q[7:4] - 4'd1;
      end else begin
        cnt_dn[7:4] = 4'd5;
        if (cnt_q[11:8] != 4'd0) begin
          cnt_dn[11:8] = cnt_q[11:8] - 4'd1;
        end else begin
          cnt_dn[11:8]  = 4'd9;
          cnt_dn[15:12] = cnt_q[15:12] - 4'd1;
        end
      end
    end
  end

  assign tick = is_run && (presc_q == TICK_LAST);

  // Next-state: clear > load > start/stop edge > tick. Lap handling is
  // independent of that chain; the display follows the next count so that
  // releasing hold shows the live value on the following cycle.
  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    done_lat_d = done_lat_q;
    done_pls_d = 1'b0;

    if (clear) begin
      state_d    = ST_STOP;
      presc_d    = '0;
      cnt_d      = '0;
      hold_d     = 1'b0;
      done_lat_d = 1'b0;
    end else begin
      if (lap_edge) begin
        hold_d = is_run ? ~hold_q : 1'b0;
      end
      if (load && !is_run) begin
        cnt_d      = {sat(load_val[15:12], 4'd5), sat(load_val[11:8], 4'd9),
                      sat(load_val[7:4], 4'd5), sat(load_val[3:0], 4'd9)};
        presc_d    = '0;
        done_lat_d = 1'b0;
      end else if (start_edge) begin
        if (is_run) begin
          state_d    = ST_STOP;
          done_lat_d = 1'b0;
        end else if (!(down && (cnt_q == '0))) begin
          state_d    = ST_RUN;
          done_lat_d = 1'b0;
        end
      end else if (tick) begin
        presc_d = '0;
        if (down) begin
          if (cnt_q <= 16'h0001) begin
            cnt_d      = '0;
            state_d    = ST_STOP;
            done_lat_d = 1'b1;
          end else begin
            cnt_d = cnt_dn;
          end
        end else begin
          cnt_d      = cnt_up;
          done_pls_d = wrap_up;
        end
      end else if (is_run) begin
        presc_d = presc_q + 26'd1;
      end
    end

    disp_d = hold_d ? disp_q : cnt_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_STOP;
      presc_q    <= '0;
      cnt_q      <= '0;
      disp_q     <= '0;
      hold_q     <= 1'b0;
      done_lat_q <= 1'b0;
      done_pls_q <= 1'b0;
      start_q    <= 1'b0;
      lap_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      cnt_q      <= cnt_d;
      disp_q     <= disp_d;
      hold_q     <= hold_d;
      done_lat_q <= done_lat_d;
      done_pls_q <= done_pls_d;
      start_q    <= start_stop;
      lap_q      <= lap;
    end
  end

  always_comb begin
    bcd     = cnt_q;
    running = is_run;
    done    = done_lat_q | done_pls_q;
    seg0    = seg_dec(disp_q[3:0]);
    seg1    = seg_dec(disp_q[7:4]);
    seg2    = seg_dec(disp_q[11:8]);
    seg3    = seg_dec(disp_q[15:12]);
  end

endmodule

// File: tb/tb_lap_stopwatch.sv
// Self-checking bench for lap_stopwatch (TICK_DIV = 4). The reference model
// keeps the count as plain elapsed seconds and derives BCD/segments from it.
module tb_lap_stopwatch;

  localparam int TDIV = 4;
  localparam bit SAL  = 1'b1;

  logic        clock = 1'b0;
  logic        reset, start_stop, clear, lap, down, load;
  logic [15:0] load_val;
  logic [15:0] bcd;
  logic [6:0]  seg0, seg1, seg2, seg3;
  logic        running, done, tick;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int m_secs, m_presc, m_disp;
  bit m_run, m_hold, m_dlat, m_dpls, m_ssp, m_lapp;
  int n_secs, n_presc, n_disp;
  bit n_run, n_hold, n_dlat, n_dpls, n_ssp, n_lapp;

  lap_stopwatch #(.TICK_DIV(TDIV), .SEG_ACTIVE_LOW(SAL)) dut (
    .clock(clock), .reset(reset), .start_stop(start_stop), .clear(clear),
    .lap(lap), .down(down), .load(load), .load_val(load_val), .bcd(bcd),
    .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3),
    .running(running), .done(done), .tick(tick)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] to_bcd(input int s);
    return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
  endfunction

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int load_secs(input logic [15:0] v);
    return min_i(int'(v[15:12]), 5) * 600 + min_i(int'(v[11:8]), 9) * 60
         + min_i(int'(v[7:4]), 5) * 10 + min_i(int'(v[3:0]), 9);
  endfunction

  function automatic logic [6:0] seg_exp(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0: p = 7'b1000000;  4'd1: p = 7'b1111001;
      4'd2: p = 7'b0100100;  4'd3: p = 7'b0110000;
      4'd4: p = 7'b0011001;  4'd5: p = 7'b0010010;
      4'd6: p = 7'b0000010;  4'd7: p = 7'b1111000;
      4'd8: p = 7'b0000000;  4'd9: p = 7'b0010000;
      default: p = 7'b1111111;
    endcase
    return SAL ? p : ~p;
  endfunction

  function automatic logic [27:0] segs_of(input int s);
    logic [15:0] b;
    b = to_bcd(s);
    return {seg_exp(b[15:12]), seg_exp(b[11:8]), seg_exp(b[7:4]), seg_exp(b[3:0])};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("bcd", 32'(bcd), 32'(to_bcd(m_secs)));
    chk("running", 32'(running), 32'(m_run));
    chk("done", 32'(done), 32'(m_dlat | m_dpls));
    chk("tick", 32'(tick), 32'(m_run && (m_presc == TDIV - 1)));
    chk("seg", 32'({seg3, seg2, seg1, seg0}), 32'(segs_of(m_disp)));
  endtask

  task automatic model_reset();
    m_secs = 0; m_presc = 0; m_disp = 0;
    m_run = 0; m_hold = 0; m_dlat = 0; m_dpls = 0; m_ssp = 0; m_lapp = 0;
  endtask

  task automatic model_next();
    bit sse, lpe, tk;
    sse = start_stop && !m_ssp;
    lpe = lap && !m_lapp;
    tk  = m_run && (m_presc == TDIV - 1);
    n_secs = m_secs; n_presc = m_presc; n_run = m_run; n_hold = m_hold;
    n_dlat = m_dlat; n_dpls = 0;
    if (clear) begin
      n_secs = 0; n_presc = 0; n_run = 0; n_hold = 0; n_dlat = 0;
    end else begin
      if (lpe) n_hold = m_run ? !m_hold : 1'b0;
      if (load && !m_run) begin
        n_secs = load_secs(load_val); n_presc = 0; n_dlat = 0;
      end else if (sse) begin
        if (m_run) begin
          n_run = 0; n_dlat = 0;
        end else if (!(down && m_secs == 0)) begin
          n_run = 1; n_dlat = 0;
        end
      end else if (tk) begin
        n_presc = 0;
        if (down) begin
          if (m_secs <= 1) begin
            n_secs = 0; n_run = 0; n_dlat = 1;
          end else begin
            n_secs = m_secs - 1;
          end
        end else begin
          n_secs = (m_secs + 1) % 3600;
          n_dpls = (m_secs == 3599);
        end
      end else if (m_run) begin
        n_presc = m_presc + 1;
      end
    end
    n_disp = n_hold ? m_disp : n_secs;
    n_ssp  = start_stop;
    n_lapp = lap;
  endtask

  // compare current outputs, then advance one clock and the model with it
  task automatic step();
    check_all();
    model_next();
    @(posedge clock);
    #1;
    m_secs = n_secs; m_presc = n_presc; m_disp = n_disp; m_run = n_run;
    m_hold = n_hold; m_dlat = n_dlat; m_dpls = n_dpls; m_ssp = n_ssp; m_lapp = n_lapp;
  endtask

  task automatic do_clear();
    clear = 1'b1; step(); clear = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1; load_val = v; step(); load = 1'b0;
  endtask

  task automatic do_start();
    start_stop = 1'b1; step(); start_stop = 1'b0;
  endtask

  initial begin
    int ntick, last_tick, ndone;

    reset = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
    down = 1'b0; load = 1'b0; load_val = '0;
    model_reset();
    #1;
    chk("rst_bcd", 32'(bcd), 32'h0);
    chk("rst_seg", 32'({seg3, seg2, seg1, seg0}), 32'({4{7'b1000000}}));
    chk("rst_flags", 32'({running, done, tick}), 32'h0);
    @(negedge clock);
    reset = 1'b1;
    step();

    // Test 1: 240 running cycles -> 60 ticks spaced by 4, 01:00
    do_start();
    ntick = 0; last_tick = -1;
    for (int i = 1; i <= 240; i++) begin
      if (tick) begin
        if (last_tick >= 0) chk("t1_tick_gap", 32'(i - last_tick), 32'd4);
        last_tick = i;
        ntick++;
      end
      step();
    end
    chk("t1_ticks", 32'(ntick), 32'd60);
    chk("t1_bcd", 32'(bcd), 32'h0100);

    // Test 2: wrap from 59:58 in up mode
    do_start();
    do_clear();
    do_load(16'h5958);
    do_start();
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 8) begin
        chk("t2_bcd", 32'(bcd), 32'h0000);
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_running", 32'(running), 32'd1);
      end
      if (done) ndone++;
      step();
    end
    chk("t2_done_cycles", 32'(ndone), 32'd1);

    // Test 3: down-count to terminal, further start ignored
    do_clear();
    down = 1'b1;
    do_load(16'h0002);
    do_start();
    repeat (8) step();
    chk("t3_bcd", 32'(bcd), 32'h0000);
    chk("t3_running", 32'(running), 32'd0);
    chk("t3_done", 32'(done), 32'd1);
    do_start();
    step();
    chk("t3_restart_flags", 32'({running, done}), 32'b01);
    chk("t3_restart_bcd", 32'(bcd), 32'h0000);
    down = 1'b0;

    // Test 4: lap hold freezes display, second lap releases it
    do_clear();
    do_load(16'h0005);
    do_start();
    lap = 1'b1; step(); lap = 1'b0;
    repeat (20) step();
    chk("t4_seg0_held", 32'(seg0), 32'(seg_exp(4'd5)));
    chk("t4_bcd", 32'(bcd), 32'h0010);
    lap = 1'b1; step(); lap = 1'b0;
    chk("t4_seg0_live", 32'(seg0), 32'(seg_exp(4'd0)));

    // Test 5: load saturation, load ignored while running, clear beats load
    do_clear();
    do_load(16'h7A9F);
    chk("t5_sat", 32'(bcd), 32'h5959);
    do_start();
    do_load(16'h0123);
    chk("t5_load_ignored", 32'(bcd), 32'h5959);
    clear = 1'b1; load = 1'b1; load_val = 16'h1111;
    step();
    clear = 1'b0; load = 1'b0;
    chk("t5_clear_load", 32'(bcd), 32'h0000);

    // Test 6: asynchronous reset mid-count at 12:34
    do_load(16'h1234);
    do_start();
    repeat (2) step();
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("t6_bcd", 32'(bcd), 32'h0);
    chk("t6_flags", 32'({running, done, tick}), 32'h0);
    chk("t6_seg", 32'({seg3, seg2, seg1, seg0}), 32'({4{7'b1000000}}));
    @(negedge clock);
    reset = 1'b1;
    step();

    // Randomized run against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) start_stop = ~start_stop;
      if ($urandom_range(0, 11) == 0) lap = ~lap;
      if ($urandom_range(0, 99) == 0) down = ~down;
      clear = ($urandom_range(0, 299) == 0);
      load  = ($urandom_range(0, 49) == 0);
      case ($urandom_range(0, 3))
        0:       load_val = 16'($urandom);
        1:       load_val = 16'h5957;
        2:       load_val = 16'h0003;
        default: load_val = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9)),
                             4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
      endcase
      step();
    end
    check_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
